// File: rtl/scan_mux.sv
// Purpose: clocked digit scanner; rotates through 2**S packed digits at a DIV-cycle rate, skipping masked digits.
// Latency: sel/dout/tick/an are registered, so they appear one cycle after the advance edge. an is held dark for BLANK cycles after each advance.
// Backpressure: none; en=0 freezes the prescaler and darkens an, and the scan resumes with the remaining slot count.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst      - synchronous active-high reset, has priority over all other inputs
//   en       - scan enable; the prescaler only counts while high
//   din      - packed digit data, digit i = din[M*i +: M]
//   digit_en - per-digit enable mask, 0 = skip the digit
//   dout     - snapshot of the selected digit, taken on each advance
//   sel      - index of the current digit
//   an       - one-hot active-high digit strobe, all-zero = dark
//   tick     - one-cycle pulse aligned with each new sel/dout
//   seg      - (only with SCAN_MUX_SEG_DECODE_EN) gfedcba segments for dout[3:0], dark when an is dark
module scan_mux #(
    parameter int S     = 2,
    parameter int M     = 4,
    parameter int DIV   = 4,
    parameter int BLANK = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [M*(2**S)-1:0]   din,
    input  logic [(2**S)-1:0]     digit_en,
    output logic [M-1:0]          dout,
    output logic [S-1:0]          sel,
    output logic [(2**S)-1:0]     an,
    output logic                  tick
`ifdef SCAN_MUX_SEG_DECODE_EN
    ,
    output logic [6:0]            seg
`endif
);

    localparam int N  = 2**S;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [BW-1:0] BLANK_LD = BW'(BLANK);

    logic [CW-1:0] cnt;
    logic [BW-1:0] blank_cnt;
    logic          armed;

    logic          advance;
    logic [S-1:0]  nxt;
    logic [S-1:0]  idx;
    logic          found;
    logic [M-1:0]  nxt_digit;

    logic [CW-1:0] cnt_d;
    logic [S-1:0]  sel_d;
    logic [M-1:0]  dout_d;
    logic [BW-1:0] blank_d;
    logic          armed_d;
    logic [N-1:0]  an_d;

    assign advance = en && (cnt == CNT_MAX);

    // Nearest enabled digit after sel, searching forward with wrap. The last
    // candidate (k = N) is sel itself; with an all-zero mask nxt stays at sel.
    always_comb begin
        nxt   = sel;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = sel + k[S-1:0];
            if (!found && digit_en[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        nxt_digit = '0;
        for (int i = 0; i < N; i++) begin
            if (nxt == i[S-1:0]) begin
                nxt_digit = din[i*M +: M];
            end
        end
    end

    // Next-state values. an is computed from the already-updated sel/blank/armed
    // so the strobe lines up with the digit value it is lighting.
    always_comb begin
        cnt_d = cnt;
        if (en) begin
            cnt_d = advance ? '0 : cnt + 1'b1;
        end

        sel_d   = advance ? nxt : sel;
        dout_d  = advance ? nxt_digit : dout;
        armed_d = armed | advance;

        // Blanking counts down on every non-advance edge, including while en=0.
        if (advance) begin
            blank_d = BLANK_LD;
        end else if (blank_cnt != '0) begin
            blank_d = blank_cnt - 1'b1;
        end else begin
            blank_d = blank_cnt;
        end

        an_d = '0;
        if (armed_d && en && (blank_d == '0) && digit_en[sel_d]) begin
            an_d[sel_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            sel       <= '0;
            dout      <= '0;
            blank_cnt <= '0;
            armed     <= 1'b0;
            tick      <= 1'b0;
            an        <= '0;
        end else begin
            cnt       <= cnt_d;
            sel       <= sel_d;
            dout      <= dout_d;
            blank_cnt <= blank_d;
            armed     <= armed_d;
            tick      <= advance;
            an        <= an_d;
        end
    end

`ifdef SCAN_MUX_SEG_DECODE_EN
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Registered alongside an so the segments go dark exactly when the strobe does.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= '0;
        end else begin
            seg <= (an_d != '0) ? seg_decode(dout_d[3:0]) : 7'h00;
        end
    end
`endif

endmodule

// File: tb/tb_scan_mux.sv
module tb_scan_mux;

    localparam int S     = 2;
    localparam int M     = 4;
    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int N     = 1 << S;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [M*N-1:0]   din;
    logic [N-1:0]     digit_en;
    logic [M-1:0]     dout;
    logic [S-1:0]     sel;
    logic [N-1:0]     an;
    logic             tick;
`ifdef SCAN_MUX_SEG_DECODE_EN
    logic [6:0]       seg;
`endif

    always #5 clk = ~clk;

    scan_mux #(.S(S), .M(M), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .din      (din),
        .digit_en (digit_en),
        .dout     (dout),
        .sel      (sel),
        .an       (an),
        .tick     (tick)
`ifdef SCAN_MUX_SEG_DECODE_EN
        ,
        .seg      (seg)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: slot phase, current digit, and edges elapsed since the
    // last advance (an may light once that reaches BLANK).
    int m_phase, m_sel, m_dout, m_since, m_an, m_seg;
    bit m_armed, m_tick;

    function automatic int seg7(input int d);
        case (d)
            0: return 'h3F;  1: return 'h06;  2: return 'h5B;  3: return 'h4F;
            4: return 'h66;  5: return 'h6D;  6: return 'h7D;  7: return 'h07;
            8: return 'h7F;  9: return 'h6F; 10: return 'h77; 11: return 'h7C;
           12: return 'h39; 13: return 'h5E; 14: return 'h79; default: return 'h71;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit adv;
        int nx;
        bit fnd;
        if (rst) begin
            m_phase = 0; m_sel = 0; m_dout = 0; m_since = 0;
            m_armed = 0; m_tick = 0; m_an = 0;
        end else begin
            adv = en && (m_phase == DIV - 1);
            if (en) m_phase = (m_phase + 1) % DIV;
            if (adv) begin
                nx  = m_sel;
                fnd = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!fnd && digit_en[(m_sel + k) % N]) begin
                        nx  = (m_sel + k) % N;
                        fnd = 1;
                    end
                end
                m_sel   = nx;
                m_dout  = int'((din >> (M * nx)) & ((1 << M) - 1));
                m_since = 0;
                m_armed = 1;
            end else if (m_since < 1000) begin
                m_since++;
            end
            m_tick = adv;
            m_an   = (m_armed && en && m_since >= BLANK && digit_en[m_sel]) ? (1 << m_sel) : 0;
        end
        m_seg = (m_an != 0) ? seg7(m_dout & 15) : 0;
    endtask

    // One clock: model follows the inputs present at the edge, outputs are
    // sampled 1 time unit later, inputs may then be changed by the caller.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("model.sel", 32'(sel), 32'(m_sel));
        chk("model.dout", 32'(dout), 32'(m_dout));
        chk("model.an", 32'(an), 32'(m_an));
        chk("model.tick", 32'(tick), 32'(m_tick));
`ifdef SCAN_MUX_SEG_DECODE_EN
        chk("model.seg", 32'(seg), 32'(m_seg));
`endif
    endtask

    typedef struct {
        bit          rst;
        bit          en;
        logic [15:0] din;
        logic [3:0]  msk;
        int          esel;
        int          edout;
        int          ean;
        bit          etick;
    } vec_t;

    function automatic vec_t mkv(bit r, int s, int d, int a, bit t);
        vec_t v;
        v.rst = r; v.en = 1'b1; v.din = 16'h4321; v.msk = 4'hF;
        v.esel = s; v.edout = d; v.ean = a; v.etick = t;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[18];
        int   tick_sels[$];
        int   nt;
        bit   found;
        logic [S-1:0] s0;
        logic [M-1:0] d0;

        rst = 1'b1; en = 1'b0; din = '0; digit_en = '0;

        // Scan rotation from reset: first tick on the 4th enabled edge, 1 dark cycle after each tick.
        tbl[0]  = mkv(1, 0, 0, 0, 0);
        tbl[1]  = mkv(0, 0, 0, 0, 0);
        tbl[2]  = mkv(0, 0, 0, 0, 0);
        tbl[3]  = mkv(0, 0, 0, 0, 0);
        tbl[4]  = mkv(0, 1, 2, 0, 1);
        tbl[5]  = mkv(0, 1, 2, 4'b0010, 0);
        tbl[6]  = mkv(0, 1, 2, 4'b0010, 0);
        tbl[7]  = mkv(0, 1, 2, 4'b0010, 0);
        tbl[8]  = mkv(0, 2, 3, 0, 1);
        tbl[9]  = mkv(0, 2, 3, 4'b0100, 0);
        tbl[10] = mkv(0, 2, 3, 4'b0100, 0);
        tbl[11] = mkv(0, 2, 3, 4'b0100, 0);
        tbl[12] = mkv(0, 3, 4, 0, 1);
        tbl[13] = mkv(0, 3, 4, 4'b1000, 0);
        tbl[14] = mkv(0, 3, 4, 4'b1000, 0);
        tbl[15] = mkv(0, 3, 4, 4'b1000, 0);
        tbl[16] = mkv(0, 0, 1, 0, 1);
        tbl[17] = mkv(0, 0, 1, 4'b0001, 0);

        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; din = tbl[i].din; digit_en = tbl[i].msk;
            cycle();
            chk($sformatf("vec%0d.sel", i), 32'(sel), 32'(tbl[i].esel));
            chk($sformatf("vec%0d.dout", i), 32'(dout), 32'(tbl[i].edout));
            chk($sformatf("vec%0d.an", i), 32'(an), 32'(tbl[i].ean));
            chk($sformatf("vec%0d.tick", i), 32'(tick), 32'(tbl[i].etick));
        end

        // Skip mask 0101 starting from sel=0: 2, 0, 2.
        digit_en = 4'b0101;
        for (int c = 0; c < 20 && tick_sels.size() < 3; c++) begin
            cycle();
            if (tick === 1'b1) tick_sels.push_back(int'(sel));
        end
        chk("skip.ticks", 32'(tick_sels.size()), 32'd3);
        if (tick_sels.size() == 3) begin
            chk("skip.sel0", 32'(tick_sels[0]), 32'd2);
            chk("skip.sel1", 32'(tick_sels[1]), 32'd0);
            chk("skip.sel2", 32'(tick_sels[2]), 32'd2);
        end

        // Single enabled digit: sel parks on 1, ticks continue, dark cycle after each tick.
        digit_en = 4'b0010;
        nt = 0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (tick === 1'b1) begin
                nt++;
                chk("single.sel", 32'(sel), 32'd1);
                chk("single.an_blank", 32'(an), 32'd0);
            end
        end
        chk("single.tickcount", 32'(nt), 32'd3);

        // Everything masked: dark, frozen, still ticking.
        digit_en = 4'b0000;
        s0 = sel; d0 = dout; nt = 0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (tick === 1'b1) nt++;
            chk("masked.an", 32'(an), 32'd0);
            chk("masked.sel", 32'(sel), 32'(s0));
            chk("masked.dout", 32'(dout), 32'(d0));
        end
        chk("masked.tickcount", 32'(nt), 32'd3);

        // en low mid-slot for 10 cycles, with din changing meanwhile.
        digit_en = 4'hF;
        found = 0;
        for (int c = 0; c < 8 && !found; c++) begin
            cycle();
            if (tick === 1'b1) found = 1;
        end
        chk("en.sync_tick", 32'(found), 32'd1);
        cycle();
        cycle();
        s0 = sel; d0 = dout;
        chk("en.lit_before", 32'(an != 0), 32'd1);
        en = 1'b0;
        din = 16'h9876;
        for (int c = 0; c < 10; c++) begin
            cycle();
            chk("en.an_dark", 32'(an), 32'd0);
            chk("en.tick", 32'(tick), 32'd0);
            chk("en.sel_hold", 32'(sel), 32'(s0));
            chk("en.dout_hold", 32'(dout), 32'(d0));
        end
        en = 1'b1;
        cycle();
        chk("en.resume_notick", 32'(tick), 32'd0);
        chk("en.resume_dout", 32'(dout), 32'(d0));
        cycle();
        chk("en.resume_tick", 32'(tick), 32'd1);

        // Reset while sel=3 is lit.
        din = 16'h4321;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            cycle();
            if (sel === 2'd3 && an === 4'b1000) found = 1;
        end
        chk("rst.reach_sel3", 32'(found), 32'd1);
        rst = 1'b1;
        cycle();
        chk("rst.sel", 32'(sel), 32'd0);
        chk("rst.dout", 32'(dout), 32'd0);
        chk("rst.an", 32'(an), 32'd0);
        chk("rst.tick", 32'(tick), 32'd0);
        rst = 1'b0;
        found = 0;
        for (int c = 0; c < 8 && !found; c++) begin
            cycle();
            chk("rst.an_dark_until_tick", 32'(an), 32'd0);
            if (tick === 1'b1) found = 1;
        end
        chk("rst.first_tick", 32'(found), 32'd1);

`ifdef SCAN_MUX_SEG_DECODE_EN
        // Digit 1 = A: segments show 77 when lit, 00 while blanked.
        din = 16'h00A0;
        digit_en = 4'b0010;
        found = 0;
        for (int c = 0; c < 16 && !found; c++) begin
            cycle();
            if (an === 4'b0010 && dout === 4'hA) found = 1;
            else if (an === 4'b0000) chk("seg.blank", 32'(seg), 32'h00);
        end
        chk("seg.lit_found", 32'(found), 32'd1);
        chk("seg.A", 32'(seg), 32'h77);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) din = M*N'($urandom);
            if ($urandom_range(0, 15) == 0) digit_en = N'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
